// File: rtl/dma_fifo_pkg.sv
// dma_fifo_pkg: width helpers and keep-mask generation for the DMA gearbox FIFO.
package dma_fifo_pkg;
  function automatic int clog2_safe(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
  function automatic int unit_w(input int iw, input int ow);
    return (iw < ow) ? iw : ow;
  endfunction
  function automatic int units(input int w, input int iw, input int ow);
    return w / unit_w(iw, ow);
  endfunction
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
  function automatic logic [63:0] keep_mask(input int n, input int lim);
    int c;
    c = (n > lim) ? lim : n;
    return (c >= 64) ? '1 : ((64'd1 << c) - 64'd1);
  endfunction
endpackage

// File: rtl/dma_unit_ram.sv
// dma_unit_ram: unit-wide register array with a multi-unit modulo write port and FWFT read port.
module dma_unit_ram #(
  parameter int U = 32,
  parameter int DEPTH = 16,
  parameter int AW = 4,
  parameter int IN_UNITS = 2,
  parameter int OUT_UNITS = 1
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [AW-1:0]           waddr,
  input  logic [IN_UNITS*U-1:0]   wdata,
  input  logic [AW-1:0]           raddr,
  output logic [OUT_UNITS*U-1:0]  rdata
);
  logic [U-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we)
      for (int i = 0; i < IN_UNITS; i++) mem[waddr + AW'(i)] <= wdata[i*U +: U];
  for (genvar r = 0; r < OUT_UNITS; r++) begin : g_rd
    assign rdata[r*U +: U] = mem[raddr + AW'(r)];
  end
endmodule

// File: rtl/dma_gearbox_fifo.sv
// dma_gearbox_fifo: width-converting staging FIFO with drain-mode partial beats and level thresholds.
module dma_gearbox_fifo
  import dma_fifo_pkg::*;
#(
  parameter int IN_WIDTH = 64,
  parameter int OUT_WIDTH = 32,
  parameter int DEPTH = 16,
  localparam int U = unit_w(IN_WIDTH, OUT_WIDTH),
  localparam int IN_UNITS = units(IN_WIDTH, IN_WIDTH, OUT_WIDTH),
  localparam int OUT_UNITS = units(OUT_WIDTH, IN_WIDTH, OUT_WIDTH),
  localparam int CW = cnt_w(DEPTH),
  localparam int AW = clog2_safe(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_WIDTH-1:0]  in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic [OUT_UNITS-1:0] out_keep,
  input  logic                 drain,
  input  logic [CW-1:0]        af_thresh,
  input  logic [CW-1:0]        ae_thresh,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic [CW-1:0]        ocup_cnt,
  output logic [CW-1:0]        free_cnt
);
  logic [CW-1:0] wr_ptr, rd_ptr, pop_n;
  logic [OUT_WIDTH-1:0] rdata;
  logic full_beat, part_beat, push, pop;
  assign ocup_cnt = wr_ptr - rd_ptr;
  assign free_cnt = CW'(DEPTH) - ocup_cnt;
  assign in_ready = free_cnt >= CW'(IN_UNITS);
  assign full_beat = ocup_cnt >= CW'(OUT_UNITS);
  assign part_beat = drain && (ocup_cnt != '0);
  assign out_valid = full_beat || part_beat;
  assign pop_n = full_beat ? CW'(OUT_UNITS) : ocup_cnt;
  assign out_keep = out_valid ? OUT_UNITS'(keep_mask(int'(pop_n), OUT_UNITS)) : '0;
  assign push = in_valid && in_ready;
  assign pop = out_valid && out_ready;
  assign almost_full = ocup_cnt >= af_thresh;
  assign almost_empty = ocup_cnt <= ae_thresh;
  // Units beyond the keep mask read stale storage, so they are forced to zero.
  for (genvar r = 0; r < OUT_UNITS; r++) begin : g_out
    assign out_data[r*U +: U] = out_keep[r] ? rdata[r*U +: U] : '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + CW'(IN_UNITS);
      if (pop) rd_ptr <= rd_ptr + pop_n;
    end
  dma_unit_ram #(
    .U(U), .DEPTH(DEPTH), .AW(AW), .IN_UNITS(IN_UNITS), .OUT_UNITS(OUT_UNITS)
  ) u_ram (
    .clk(clk),
    .we(push && !clear),
    .waddr(wr_ptr[AW-1:0]),
    .wdata(in_data),
    .raddr(rd_ptr[AW-1:0]),
    .rdata(rdata)
  );
endmodule

// File: tb/tb_dma_gearbox_fifo.sv
// tb_dma_gearbox_fifo: downsize (64->32) and upsize (32->64) instances against unit-queue models.
module tb_dma_gearbox_fifo;
  logic clk = 0, rst_n = 0, clear = 0, in_valid = 0, out_ready = 0, drain = 0;
  logic [4:0] af_th = 5'd14, ae_th = 5'd2;
  logic [63:0] d_in_data = '0;
  logic [31:0] d_out_data;
  logic [0:0] d_out_keep;
  logic d_in_ready, d_out_valid, d_af, d_ae;
  logic [4:0] d_ocup, d_free;
  logic [31:0] u_in_data = '0;
  logic [63:0] u_out_data;
  logic [1:0] u_out_keep;
  logic u_in_ready, u_out_valid, u_af, u_ae;
  logic [4:0] u_ocup, u_free;
  logic [31:0] qd[$], qu[$];
  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  dma_gearbox_fifo #(.IN_WIDTH(64), .OUT_WIDTH(32), .DEPTH(16)) dut_dn (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(d_in_ready),
    .in_data(d_in_data), .out_valid(d_out_valid), .out_ready(out_ready), .out_data(d_out_data),
    .out_keep(d_out_keep), .drain(drain), .af_thresh(af_th), .ae_thresh(ae_th),
    .almost_full(d_af), .almost_empty(d_ae), .ocup_cnt(d_ocup), .free_cnt(d_free));

  dma_gearbox_fifo #(.IN_WIDTH(32), .OUT_WIDTH(64), .DEPTH(16)) dut_up (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(u_in_ready),
    .in_data(u_in_data), .out_valid(u_out_valid), .out_ready(out_ready), .out_data(u_out_data),
    .out_keep(u_out_keep), .drain(drain), .af_thresh(af_th), .ae_thresh(ae_th),
    .almost_full(u_af), .almost_empty(u_ae), .ocup_cnt(u_ocup), .free_cnt(u_free));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_d_ocup"}, d_ocup, 0);
    check({tag, "_d_free"}, d_free, 16);
    check({tag, "_d_rdy"}, d_in_ready, 1);
    check({tag, "_d_ov"}, d_out_valid, 0);
    check({tag, "_d_data"}, d_out_data, 0);
    check({tag, "_d_keep"}, d_out_keep, 0);
    check({tag, "_d_ae"}, d_ae, 1);
    check({tag, "_d_af"}, d_af, af_th == 0);
    check({tag, "_u_ov"}, u_out_valid, 0);
    check({tag, "_u_data"}, u_out_data, 0);
    check({tag, "_u_free"}, u_free, 16);
  endtask

  // One clock: compare both instances against their models, then advance the models.
  task automatic step();
    int od, ou, up;
    logic [63:0] ed, eu;
    logic [1:0] ek;
    logic full, part;
    @(negedge clk);
    od = qd.size();
    ou = qu.size();
    ed = 0;
    if (od > 0) ed = {32'd0, qd[0]};
    check("d_ocup", d_ocup, od);
    check("d_free", d_free, 16 - od);
    check("d_rdy", d_in_ready, (16 - od) >= 2);
    check("d_ov", d_out_valid, od >= 1);
    check("d_data", d_out_data, ed);
    check("d_keep", d_out_keep, od >= 1);
    check("d_af", d_af, od >= int'(af_th));
    check("d_ae", d_ae, od <= int'(ae_th));
    full = ou >= 2;
    part = drain && ou == 1;
    eu = 0;
    ek = 0;
    up = 0;
    if (full) begin eu = {qu[1], qu[0]}; ek = 2'b11; up = 2; end
    else if (part) begin eu = {32'd0, qu[0]}; ek = 2'b01; up = 1; end
    check("u_ocup", u_ocup, ou);
    check("u_free", u_free, 16 - ou);
    check("u_rdy", u_in_ready, (16 - ou) >= 1);
    check("u_ov", u_out_valid, full || part);
    check("u_data", u_out_data, eu);
    check("u_keep", u_out_keep, ek);
    check("u_af", u_af, ou >= int'(af_th));
    check("u_ae", u_ae, ou <= int'(ae_th));
    if (clear) begin
      qd.delete();
      qu.delete();
    end else begin
      if (out_ready && od >= 1) void'(qd.pop_front());
      if (in_valid && (16 - od) >= 2) begin
        qd.push_back(d_in_data[31:0]);
        qd.push_back(d_in_data[63:32]);
      end
      if (out_ready) repeat (up) void'(qu.pop_front());
      if (in_valid && ou < 16) qu.push_back(u_in_data);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rand_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      drain = ($urandom_range(0, 3) == 0);
      d_in_data = {$urandom, $urandom};
      u_in_data = $urandom;
      if (i % 8 == 0) begin
        af_th = 5'($urandom_range(0, 16));
        ae_th = 5'($urandom_range(0, 16));
      end
      step();
      check("sum", 64'(d_ocup) + 64'(d_free), 16);
    end
  endtask

  task automatic do_clear();
    in_valid = 0; out_ready = 0; drain = 0; clear = 1;
    step();
    clear = 0;
  endtask

  initial begin
    #12;
    check_reset_outputs("rst");
    rst_n = 1;
    @(posedge clk);
    #1;
    // Downsize: one 64-bit push emerges as two 32-bit beats, low unit first.
    in_valid = 1; out_ready = 1;
    d_in_data = 64'h11112222_33334444;
    u_in_data = 32'h0;
    step();
    in_valid = 0;
    check("dn_occ2", d_ocup, 2);
    check("dn_beat0", d_out_data, 64'h33334444);
    step();
    check("dn_occ1", d_ocup, 1);
    check("dn_beat1", d_out_data, 64'h11112222);
    step();
    check("dn_occ0", d_ocup, 0);
    // Fill to capacity, then a push attempt and pop in the same cycle.
    do_clear();
    af_th = 14; ae_th = 2;
    in_valid = 1;
    for (int i = 0; i < 8; i++) begin
      d_in_data = {$urandom, $urandom};
      u_in_data = $urandom;
      step();
    end
    check("fill_occ", d_ocup, 16);
    check("fill_free", d_free, 0);
    check("fill_rdy", d_in_ready, 0);
    check("fill_af", d_af, 1);
    out_ready = 1;
    step();
    check("fill_pp_occ", d_ocup, 15);
    check("fill_pp_rdy", d_in_ready, 0);
    // Upsize: A,B,C -> {B,A} full beat, then {0,C} partial under drain.
    do_clear();
    in_valid = 1;
    u_in_data = 32'hAAAA_0001; step();
    u_in_data = 32'hBBBB_0002; step();
    u_in_data = 32'hCCCC_0003; step();
    in_valid = 0;
    check("up_full", u_out_data, 64'hBBBB0002_AAAA0001);
    check("up_fkeep", u_out_keep, 2'b11);
    out_ready = 1;
    step();
    check("up_nodrain_ov", u_out_valid, 0);
    drain = 1;
    #1;
    check("up_part", u_out_data, 64'h00000000_CCCC0003);
    check("up_pkeep", u_out_keep, 2'b01);
    check("up_pocc", u_ocup, 1);
    step();
    check("up_drained_occ", u_ocup, 0);
    check("up_drained_ov", u_out_valid, 0);
    drain = 0;
    // Random traffic crossing pointer wrap many times.
    do_clear();
    rand_cycles(200);
    // Clear with concurrent push and pop at six occupied units.
    do_clear();
    af_th = 14; ae_th = 2;
    in_valid = 1;
    repeat (3) begin d_in_data = {$urandom, $urandom}; u_in_data = $urandom; step(); end
    check("clr_pre_occ", d_ocup, 6);
    in_valid = 1; out_ready = 1; clear = 1;
    step();
    clear = 0;
    check("clr_occ", d_ocup, 0);
    check("clr_ov", d_out_valid, 0);
    check("clr_rdy", d_in_ready, 1);
    check("clr_ae", d_ae, 1);
    // Asynchronous reset mid-burst, between clock edges.
    rand_cycles(12);
    #2;
    rst_n = 0;
    #1;
    check_reset_outputs("arst");
    qd.delete();
    qu.delete();
    in_valid = 0; out_ready = 0; drain = 0;
    #1;
    rst_n = 1;
    step();
    rand_cycles(40);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
